load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 66 ++++++
 rtl/load_extend.sv | 38 +++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - FSM state type, RV32I size codes and byte-lane helpers for the load/store unit
// Contents:
//   lsu_state_e       : IDLE / REQ / WAIT encoding of the 2-bit access FSM
//   F3_* / SZ_*       : funct3 codes and the size field (funct3[1:0])
//   funct3_known()    : funct3 is one of B, H, W, BU, HU
//   misaligned()      : access size does not fit the low address bits
//   mask_gen()        : byte enables for an access
//   lane_data()       : store data replicated across byte lanes
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic funct3_known(input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3[1:0])
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] mask_gen(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] m;
        case (f3[1:0])
            SZ_B:    m = 4'b0001 << lo;
            SZ_H:    m = 4'b0011 << lo;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // The memory writes only the enabled lanes, so replicating the right-aligned
    // value puts it under whichever lane the mask selects.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            SZ_B:    d = {4{wd[7:0]}};
            SZ_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane select and sign/zero extension
// Ports:
//   i_word    in  32  word returned by memory
//   i_addr_lo in  2   byte address bits 1:0 of the access
//   i_funct3  in  3   RV32I size/sign code (bit 2 set = unsigned)
//   o_data    out 32  right-aligned, extended load result
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign_byte;
    logic        w_sign_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half      = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        w_sign_byte = w_byte[7]  & ~i_funct3[2];
        w_sign_half = w_half[15] & ~i_funct3[2];
        case (i_funct3[1:0])
            SZ_B:    o_data = {{24{w_sign_byte}}, w_byte};
            SZ_H:    o_data = {{16{w_sign_half}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: one outstanding access, IDLE -> REQ -> WAIT
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   lsu_valid/load/store/funct3       core operation request
//   lsu_addr, lsu_wdata               byte address, right-aligned store data
//   lsu_ready, lsu_stall              accept window (IDLE only), pipeline hold
//   lsu_done, lsu_err, lsu_rdata      completion pulse, error pulse, load result
//   data_mem_request, data_mem_we_re  one-cycle memory strobe, write(1)/read(0)
//   mem_address, mem_wdata, mem_mask  word address, lane data, byte enables
//   mem_load                          read qualifier
//   data_mem_valid, mem_rdata         memory completion and read word
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        lsu_load,
    input  logic        lsu_store,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] lsu_rdata,
    output logic        data_mem_request,
    output logic        data_mem_we_re,
    output logic [7:0]  mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    output logic        mem_load,
    input  logic        data_mem_valid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e  r_state;
    logic [CW-1:0] r_cnt;
    logic        r_store;
    logic        r_load;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [7:0]  r_mem_address;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_mask;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_legal_op;
    logic        w_accept;
    logic        w_misaligned;
    logic [31:0] w_ext;
    logic        w_unused_addr;

    // Both type flags high, or an unknown size code, is a no-op.
    assign w_legal_op   = (lsu_load ^ lsu_store) & funct3_known(lsu_funct3);
    assign w_accept     = lsu_valid & w_legal_op & (r_state == ST_IDLE);
    assign w_misaligned = misaligned(lsu_funct3, lsu_addr[1:0]);
    // The data memory decodes only a 256-word window.
    assign w_unused_addr = ^lsu_addr[31:10];

    load_extend u_load_extend (
        .i_word    (mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_store       <= 1'b0;
            r_load        <= 1'b0;
            r_funct3      <= '0;
            r_addr_lo     <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_mask    <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_misaligned) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state       <= ST_REQ;
                            r_store       <= lsu_store;
                            r_load        <= lsu_load;
                            r_funct3      <= lsu_funct3;
                            r_addr_lo     <= lsu_addr[1:0];
                            r_mem_address <= lsu_addr[9:2];
                            r_mem_mask    <= mask_gen(lsu_funct3, lsu_addr[1:0]);
                            r_mem_wdata   <= lane_data(lsu_funct3, lsu_wdata);
                        end
                    end
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    // Valid is tested first so it wins over a same-cycle timeout.
                    if (data_mem_valid) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        if (r_load) begin
                            r_rdata <= w_ext;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign lsu_ready        = (r_state == ST_IDLE);
    assign lsu_stall        = (lsu_valid & w_legal_op) | (r_state != ST_IDLE);
    assign lsu_done         = r_done;
    assign lsu_err          = r_err;
    assign lsu_rdata        = r_rdata;
    assign data_mem_request = (r_state == ST_REQ);
    assign data_mem_we_re   = r_store;
    assign mem_load         = r_load;
    assign mem_address      = r_mem_address;
    assign mem_wdata        = r_mem_wdata;
    assign mem_mask         = r_mem_mask;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid = 1'b0;
    logic        lsu_load = 1'b0;
    logic        lsu_store = 1'b0;
    logic [2:0]  lsu_funct3 = 3'd0;
    logic [31:0] lsu_addr = 32'd0;
    logic [31:0] lsu_wdata = 32'd0;
    logic        data_mem_valid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        lsu_ready, lsu_stall, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        data_mem_request, data_mem_we_re, mem_load;
    logic [7:0]  mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_load(lsu_load), .lsu_store(lsu_store),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_ready(lsu_ready), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
        .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
        .data_mem_request(data_mem_request), .data_mem_we_re(data_mem_we_re),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_load(mem_load), .data_mem_valid(data_mem_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        ld;
        logic [7:0]  adr;
        logic [3:0]  mask;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   total = 0;
    int   bad = 0;

    logic [31:0] model_rdata = 32'd0;
    logic [31:0] mon_held = 32'd0;
    logic        seen_we;
    logic [7:0]  seen_adr;
    logic [3:0]  seen_mask;
    logic [31:0] seen_wd;
    req_t        mon_req;
    rsp_t        mon_rsp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules, written from the ISA meaning of each size code.
    function automatic int size_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int     n;
        longint span;
        longint v;
        n    = size_bytes(f3);
        span = longint'(1) << (8 * n);
        v    = (longint'({32'd0, word}) >> (8 * (addr % 4))) % span;
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2)
            v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = size_bytes(f3);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // Monitor: every request and every done/err pulse is matched against the queues.
    always @(negedge clk) begin
        if (rst) begin
            mon_held = 32'd0;
        end else begin
            if (data_mem_request) begin
                if (req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_request: got addr %h want none", mem_address);
                end else begin
                    mon_req = req_q.pop_front();
                    check("req_we_re", {31'd0, data_mem_we_re}, {31'd0, mon_req.we});
                    check("req_mem_load", {31'd0, mem_load}, {31'd0, mon_req.ld});
                    check("req_address", {24'd0, mem_address}, {24'd0, mon_req.adr});
                    check("req_mask", {28'd0, mem_mask}, {28'd0, mon_req.mask});
                    check("req_wdata", mem_wdata, mon_req.wd);
                    seen_we   = data_mem_we_re;
                    seen_adr  = mem_address;
                    seen_mask = mem_mask;
                    seen_wd   = mem_wdata;
                end
            end
            if (lsu_done || lsu_err) begin
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_response: got done=%0b err=%0b want none", lsu_done, lsu_err);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    check("rsp_err", {31'd0, lsu_err}, {31'd0, mon_rsp.err});
                    check("rsp_done", {31'd0, lsu_done}, {31'd0, ~mon_rsp.err});
                    mon_held = mon_rsp.rd;
                end
            end
            check("rdata_value", lsu_rdata, mon_held);
        end
    end

    // Drives one operation from an IDLE cycle (#1 after an edge). Returns #1 after
    // the edge that shows the done/err pulse.
    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int delay, input logic [31:0] rd,
                         input logic hold);
        int   n;
        logic mis;
        req_t q;
        rsp_t r;
        n   = size_bytes(f3);
        mis = (addr % 32'(n)) != 0;
        lsu_valid = 1'b1; lsu_load = ld; lsu_store = ~ld;
        lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
        #1;
        check("stall_on_valid", {31'd0, lsu_stall}, 32'd1);
        if (mis) begin
            r.err = 1'b1; r.rd = model_rdata;
            rsp_q.push_back(r);
            @(posedge clk); #1;
            lsu_valid = 1'b0;
            check("misalign_err", {31'd0, lsu_err}, 32'd1);
            check("misalign_no_req", {31'd0, data_mem_request}, 32'd0);
            check("misalign_ready", {31'd0, lsu_ready}, 32'd1);
            return;
        end
        q.we = ~ld; q.ld = ld; q.adr = addr[9:2];
        q.mask = 4'(((1 << n) - 1) << (addr % 4));
        q.wd = ref_wdata(f3, wd);
        req_q.push_back(q);
        @(posedge clk); #1;
        check("request_cycle1", {31'd0, data_mem_request}, 32'd1);
        lsu_valid = hold; lsu_addr = $urandom;
        data_mem_valid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(posedge clk); #1;
        data_mem_valid = 1'b0;
        check("no_request_wait", {31'd0, data_mem_request}, 32'd0);
        check("not_ready_wait", {31'd0, lsu_ready}, 32'd0);
        if (delay >= T) begin
            r.err = 1'b1; r.rd = model_rdata;
            rsp_q.push_back(r);
            for (int i = 0; i < T; i++) begin
                lsu_valid = (i == T - 1) ? 1'b0 : hold;
                @(posedge clk); #1;
            end
            check("timeout_err", {31'd0, lsu_err}, 32'd1);
            check("timeout_idle", {31'd0, lsu_ready}, 32'd1);
        end else begin
            if (ld) model_rdata = ref_load(f3, addr, rd);
            r.err = 1'b0; r.rd = model_rdata;
            rsp_q.push_back(r);
            for (int i = 0; i < delay; i++) begin
                lsu_valid = hold;
                @(posedge clk); #1;
            end
            lsu_valid = 1'b0; data_mem_valid = 1'b1; mem_rdata = rd;
            @(posedge clk); #1;
            data_mem_valid = 1'b0; mem_rdata = $urandom;
            check("done_latency", {31'd0, lsu_done}, 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, lsu_ready}, 32'd1);
        check({tag, "_request"}, {31'd0, data_mem_request}, 32'd0);
        check({tag, "_we_re"}, {31'd0, data_mem_we_re}, 32'd0);
        check({tag, "_mem_load"}, {31'd0, mem_load}, 32'd0);
        check({tag, "_done"}, {31'd0, lsu_done}, 32'd0);
        check({tag, "_err"}, {31'd0, lsu_err}, 32'd0);
        check({tag, "_mask"}, {28'd0, mem_mask}, 32'd0);
        check({tag, "_address"}, {24'd0, mem_address}, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_rdata"}, lsu_rdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  load_codes[5];
        int          sel;
        int          dly;
        load_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        check("sw_address", {24'd0, seen_adr}, 32'h41);
        check("sw_mask", {28'd0, seen_mask}, 32'hF);
        check("sw_wdata", seen_wd, 32'hDEAD_BEEF);
        check("sw_we_re", {31'd0, seen_we}, 32'd1);

        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 2, 32'h0, 1'b0);
        check("sb_mask", {28'd0, seen_mask}, 32'h8);
        check("sb_wdata", seen_wd, 32'hA5A5_A5A5);

        issue(1'b1, 3'b000, 32'h0000_0102, 32'h0, 1, 32'h0080_0000, 1'b0);
        check("lb_result", lsu_rdata, 32'hFFFF_FF80);
        issue(1'b1, 3'b100, 32'h0000_0102, 32'h0, 0, 32'h0080_0000, 1'b0);
        check("lbu_result", lsu_rdata, 32'h0000_0080);
        issue(1'b1, 3'b101, 32'h0000_0102, 32'h0, 3, 32'hBEEF_0000, 1'b0);
        check("lhu_result", lsu_rdata, 32'h0000_BEEF);

        issue(1'b1, 3'b010, 32'h0000_0006, 32'h0, 0, 32'h0, 1'b0);
        issue(1'b1, 3'b010, 32'h0000_0010, 32'h0, T, 32'h0, 1'b0);
        check("timeout_keeps_rdata", lsu_rdata, 32'h0000_BEEF);
        issue(1'b1, 3'b010, 32'h0000_0014, 32'h0, T - 1, 32'h1357_2468, 1'b1);
        check("valid_last_wait_cycle", lsu_rdata, 32'h1357_2468);

        // Both type flags high: ignored.
        lsu_valid = 1'b1; lsu_load = 1'b1; lsu_store = 1'b1; lsu_funct3 = 3'b010;
        lsu_addr = 32'h20;
        #1;
        check("noop_stall", {31'd0, lsu_stall}, 32'd0);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        check("noop_no_request", {31'd0, data_mem_request}, 32'd0);
        check("noop_ready", {31'd0, lsu_ready}, 32'd1);

        // Reset in the middle of WAIT abandons the access.
        begin
            req_t q;
            q.we = 1'b0; q.ld = 1'b1; q.adr = 8'h04; q.mask = 4'hF; q.wd = 32'h1234_5678;
            req_q.push_back(q);
        end
        lsu_valid = 1'b1; lsu_load = 1'b1; lsu_store = 1'b0; lsu_funct3 = 3'b010;
        lsu_addr = 32'h10; lsu_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        model_rdata = 32'd0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", {31'd0, lsu_ready}, 32'd1);
        data_mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        data_mem_valid = 1'b0;
        @(posedge clk); #1;
        check("stray_valid_no_done", {31'd0, lsu_done}, 32'd0);

        for (int k = 0; k < 150; k++) begin
            ld = 1'($urandom_range(0, 1));
            sel = ld ? $urandom_range(0, 4) : $urandom_range(0, 2);
            f3 = load_codes[sel];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0)
                addr = addr & ~(32'(size_bytes(f3)) - 32'd1);
            sel = $urandom_range(0, 19);
            dly = (sel == 0) ? T : (sel == 1) ? T - 1 : $urandom_range(0, 6);
            issue(ld, f3, addr, $urandom, dly, $urandom, 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
